// File: rtl/stq_pkg.sv
// stq_pkg: shared store-queue sizing, wrap-bit pointer type and one-hot decode
package stq_pkg;
    localparam int BUF_COUNT = 32;
    localparam int PTR_W = 5;
    typedef struct packed {
        logic             wrap;
        logic [PTR_W-1:0] idx;
    } ptr_t;
    function automatic logic [BUF_COUNT-1:0] onehot(input logic [PTR_W-1:0] i);
        return BUF_COUNT'(1) << i;
    endfunction
endpackage

// File: rtl/stq_ptr_range_dec.sv
// stq_ptr_range_dec: mask of up to two consecutive entries starting at start, wrapping 31 -> 0
module stq_ptr_range_dec
    import stq_pkg::*;
(
    input  logic [PTR_W-1:0]     start,
    input  logic [1:0]           cnt,
    output logic [BUF_COUNT-1:0] mask
);
    logic [PTR_W-1:0] nxt;
    assign nxt  = start + PTR_W'(1);
    assign mask = (cnt != 2'd0 ? onehot(start) : '0) | (cnt[1] ? onehot(nxt) : '0);
endmodule

// File: rtl/stq_alloc_ctrl.sv
// stq_alloc_ctrl: store-queue allocate/commit/drain pointer scheduler; STQ_DUAL_DRAIN_EN adds a second drain port
module stq_alloc_ctrl
    import stq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           alloc_req,
    output logic [PTR_W-1:0]     alloc_idx0,
    output logic [PTR_W-1:0]     alloc_idx1,
    output logic [BUF_COUNT-1:0] wrt0_en,
    output logic [BUF_COUNT-1:0] wrt1_en,
    output logic                 stall,
    input  logic [1:0]           commit_cnt,
    output logic [BUF_COUNT-1:0] passe_en,
    input  logic                 excpt,
    output logic                 drain_valid,
    output logic [PTR_W-1:0]     drain_idx,
    input  logic                 drain_ready,
`ifdef STQ_DUAL_DRAIN_EN
    output logic                 drain_valid1,
    output logic [PTR_W-1:0]     drain_idx1,
    input  logic                 drain_ready1,
`endif
    output logic [BUF_COUNT-1:0] free_en,
    output logic [PTR_W:0]       occ,
    output logic                 err
);
    ptr_t head, ret, tail, head_nx, ret_nx, tail_nx;
    logic [PTR_W:0] uncommitted;
    logic req_bad, cnt_bad, alloc_ok, en0, en1, fire0, fire1;
    logic [1:0] cc_lim, n_commit, free_cnt, grant;
    assign occ         = tail - head;
    assign uncommitted = tail - ret;
    assign stall       = occ > (PTR_W+1)'(BUF_COUNT - 2);
    assign alloc_idx0  = tail.idx;
    assign alloc_idx1  = tail.idx + PTR_W'(1);
    assign drain_valid = head != ret;
    assign drain_idx   = head.idx;
`ifdef STQ_DUAL_DRAIN_EN
    logic [PTR_W:0] committed;
    assign committed    = ret - head;
    assign drain_valid1 = committed > (PTR_W+1)'(1);
    assign drain_idx1   = head.idx + PTR_W'(1);
    assign fire1        = fire0 & drain_valid1 & drain_ready1;
`else
    assign fire1 = 1'b0;
`endif
    always_comb begin
        req_bad  = ((|alloc_req) & stall) | (alloc_req == 2'b10);
        alloc_ok = ~rst & ~excpt & ~req_bad;
        en0      = alloc_ok & alloc_req[0];
        en1      = alloc_ok & alloc_req[1];
        grant    = {en1, en0 & ~en1};
        cc_lim   = commit_cnt[1] ? 2'd2 : commit_cnt;
        cnt_bad  = {{(PTR_W-1){1'b0}}, commit_cnt} > uncommitted;
        // commit never passes tail: clamp to what is actually outstanding
        n_commit = rst ? 2'd0 : cnt_bad ? uncommitted[1:0] : cc_lim;
        fire0    = ~rst & drain_valid & drain_ready;
        free_cnt = {fire1, fire0 & ~fire1};
        ret_nx   = ret + {{(PTR_W-1){1'b0}}, n_commit};
        head_nx  = head + {{(PTR_W-1){1'b0}}, free_cnt};
        tail_nx  = excpt ? ret_nx : ptr_t'(tail + {{(PTR_W-1){1'b0}}, grant});
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            ret  <= '0;
            tail <= '0;
            err  <= 1'b0;
        end else begin
            head <= head_nx;
            ret  <= ret_nx;
            tail <= tail_nx;
            err  <= err | req_bad | cnt_bad | (commit_cnt == 2'd3);
        end
    end
    stq_ptr_range_dec u_wrt0 (.start(alloc_idx0), .cnt({1'b0, en0}), .mask(wrt0_en));
    stq_ptr_range_dec u_wrt1 (.start(alloc_idx1), .cnt({1'b0, en1}), .mask(wrt1_en));
    stq_ptr_range_dec u_passe (.start(ret.idx), .cnt(n_commit), .mask(passe_en));
    stq_ptr_range_dec u_free (.start(head.idx), .cnt(free_cnt), .mask(free_en));
endmodule

// File: tb/tb_stq_alloc_ctrl.sv
// tb_stq_alloc_ctrl: directed bench with an unbounded-integer pointer model checked every cycle
module tb_stq_alloc_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] alloc_req = '0, commit_cnt = '0;
    logic excpt = 1'b0, drain_ready = 1'b0, drain_ready1 = 1'b0;
    logic [4:0] alloc_idx0, alloc_idx1, drain_idx;
    logic [31:0] wrt0_en, wrt1_en, passe_en, free_en;
    logic stall, drain_valid, err;
    logic [5:0] occ;
`ifdef STQ_DUAL_DRAIN_EN
    logic drain_valid1;
    logic [4:0] drain_idx1;
`endif
    int n_cmp = 0, n_bad = 0;
    int m_h = 0, m_r = 0, m_t = 0, x_h = 0, x_r = 0, x_t = 0;
    bit m_err = 0, x_err = 0;

    stq_alloc_ctrl dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req),
        .alloc_idx0(alloc_idx0), .alloc_idx1(alloc_idx1),
        .wrt0_en(wrt0_en), .wrt1_en(wrt1_en), .stall(stall),
        .commit_cnt(commit_cnt), .passe_en(passe_en), .excpt(excpt),
        .drain_valid(drain_valid), .drain_idx(drain_idx), .drain_ready(drain_ready),
`ifdef STQ_DUAL_DRAIN_EN
        .drain_valid1(drain_valid1), .drain_idx1(drain_idx1), .drain_ready1(drain_ready1),
`endif
        .free_en(free_en), .occ(occ), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bit_at(input int k);
        return 32'd1 << (k % 32);
    endfunction

    // Model: pointers are ever-increasing counts of allocated/committed/drained stores
    always @(negedge clk) begin
        int occ_m, avail, n, fire, grant;
        bit stall_m, bad;
        logic [31:0] pm, fm;
        if (!rst) begin
            occ_m   = m_t - m_h;
            stall_m = (32 - occ_m) < 2;
            bad     = (alloc_req != 2'b00 && stall_m) || alloc_req == 2'b10;
            grant   = (bad || excpt) ? 0 : (alloc_req == 2'b11 ? 2 : (alloc_req == 2'b01 ? 1 : 0));
            avail   = m_t - m_r;
            n       = int'(commit_cnt) < avail ? int'(commit_cnt) : avail;
            pm      = '0;
            for (int k = 0; k < n; k++) pm |= bit_at(m_r + k);
            fire    = (m_h < m_r && drain_ready) ? 1 : 0;
`ifdef STQ_DUAL_DRAIN_EN
            if (fire == 1 && drain_ready1 && m_r - m_h >= 2) fire = 2;
            chk("drain_valid1", 32'(drain_valid1), 32'(m_r - m_h >= 2));
            chk("drain_idx1", 32'(drain_idx1), (m_h + 1) % 32);
`endif
            fm = '0;
            for (int k = 0; k < fire; k++) fm |= bit_at(m_h + k);
            chk("occ", 32'(occ), occ_m);
            chk("stall", 32'(stall), 32'(stall_m));
            chk("alloc_idx0", 32'(alloc_idx0), m_t % 32);
            chk("alloc_idx1", 32'(alloc_idx1), (m_t + 1) % 32);
            chk("wrt0_en", wrt0_en, grant >= 1 ? bit_at(m_t) : 32'd0);
            chk("wrt1_en", wrt1_en, grant == 2 ? bit_at(m_t + 1) : 32'd0);
            chk("passe_en", passe_en, pm);
            chk("drain_valid", 32'(drain_valid), 32'(m_h < m_r));
            chk("drain_idx", 32'(drain_idx), m_h % 32);
            chk("free_en", free_en, fm);
            chk("err", 32'(err), 32'(m_err));
            x_h   = m_h + fire;
            x_r   = m_r + n;
            x_t   = excpt ? x_r : m_t + grant;
            x_err = m_err | bad | (int'(commit_cnt) > avail);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_h = 0; m_r = 0; m_t = 0; m_err = 0;
        end else begin
            m_h = x_h; m_r = x_r; m_t = x_t; m_err = x_err;
        end
    end

    task automatic drive(input logic [1:0] rq, input logic [1:0] cc, input logic ex,
                         input logic dr, input logic dr1 = 1'b0);
        @(posedge clk);
        #1;
        alloc_req = rq; commit_cnt = cc; excpt = ex; drain_ready = dr; drain_ready1 = dr1;
        #1;
    endtask

    task automatic reset_dut;
        @(posedge clk);
        #1;
        rst = 1'b1; alloc_req = '0; commit_cnt = '0; excpt = 1'b0; drain_ready = 1'b0; drain_ready1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset_dut();
        chk("rst_occ", 32'(occ), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_drain_valid", 32'(drain_valid), 0);
        chk("rst_err", 32'(err), 0);
        for (int i = 0; i < 16; i++) begin
            drive(2'b11, 2'd0, 1'b0, 1'b0);
            chk("fill_idx0", 32'(alloc_idx0), 2 * i);
            chk("fill_idx1", 32'(alloc_idx1), 2 * i + 1);
            chk("fill_wrt1", wrt1_en, 32'd1 << (2 * i + 1));
            chk("fill_stall", 32'(stall), 0);
        end
        drive(2'b11, 2'd0, 1'b0, 1'b0);
        chk("full_occ", 32'(occ), 32);
        chk("full_stall", 32'(stall), 1);
        chk("full_wrt0", wrt0_en, 0);
        drive(2'b00, 2'd0, 1'b0, 1'b0);
        chk("full_err", 32'(err), 1);

        reset_dut();
        drive(2'b11, 2'd0, 1'b0, 1'b1);
        drive(2'b11, 2'd0, 1'b0, 1'b1);
        drive(2'b00, 2'd2, 1'b0, 1'b1);
        chk("cm_passe0", passe_en, 32'h3);
        chk("cm_nodrain", 32'(drain_valid), 0);
        drive(2'b00, 2'd2, 1'b0, 1'b1);
        chk("cm_passe1", passe_en, 32'hC);
        chk("cm_free0", free_en, 32'h1);
        drive(2'b00, 2'd0, 1'b0, 1'b1);
        chk("cm_free1", free_en, 32'h2);
        drive(2'b00, 2'd0, 1'b0, 1'b1);
        chk("cm_free2", free_en, 32'h4);
        drive(2'b00, 2'd0, 1'b0, 1'b1);
        chk("cm_free3", free_en, 32'h8);
        drive(2'b00, 2'd0, 1'b0, 1'b1);
        chk("cm_occ", 32'(occ), 0);
        chk("cm_empty", 32'(drain_valid), 0);

        reset_dut();
        repeat (15) drive(2'b11, 2'd0, 1'b0, 1'b1);
        repeat (15) drive(2'b00, 2'd2, 1'b0, 1'b1);
        repeat (16) drive(2'b00, 2'd0, 1'b0, 1'b1);
        drive(2'b11, 2'd0, 1'b0, 1'b0);
        chk("wrap_occ0", 32'(occ), 0);
        chk("wrap_wrt0a", wrt0_en, 32'h4000_0000);
        chk("wrap_wrt1a", wrt1_en, 32'h8000_0000);
        drive(2'b11, 2'd0, 1'b0, 1'b0);
        chk("wrap_wrt0b", wrt0_en, 32'h1);
        chk("wrap_wrt1b", wrt1_en, 32'h2);
        drive(2'b00, 2'd0, 1'b0, 1'b0);
        chk("wrap_occ4", 32'(occ), 4);

        reset_dut();
        repeat (3) drive(2'b11, 2'd0, 1'b0, 1'b0);
        drive(2'b00, 2'd2, 1'b0, 1'b0);
        drive(2'b11, 2'd1, 1'b1, 1'b0);
        chk("ex_wrt0", wrt0_en, 0);
        chk("ex_wrt1", wrt1_en, 0);
        chk("ex_passe", passe_en, 32'h4);
        drive(2'b00, 2'd0, 1'b0, 1'b1);
        chk("ex_tail", 32'(alloc_idx0), 3);
        chk("ex_occ", 32'(occ), 3);
        chk("ex_free0", free_en, 32'h1);
        drive(2'b00, 2'd0, 1'b0, 1'b1);
        chk("ex_free1", free_en, 32'h2);
        drive(2'b00, 2'd0, 1'b0, 1'b1);
        chk("ex_free2", free_en, 32'h4);
        drive(2'b00, 2'd0, 1'b0, 1'b1);
        chk("ex_done", 32'(drain_valid), 0);
        chk("ex_err", 32'(err), 0);

        reset_dut();
        drive(2'b01, 2'd0, 1'b0, 1'b0);
        drive(2'b00, 2'd2, 1'b0, 1'b0);
        chk("over_passe", passe_en, 32'h1);
        drive(2'b00, 2'd0, 1'b0, 1'b0);
        chk("over_err", 32'(err), 1);

        reset_dut();
        drive(2'b10, 2'd0, 1'b0, 1'b0);
        chk("bad_wrt0", wrt0_en, 0);
        chk("bad_wrt1", wrt1_en, 0);
        drive(2'b00, 2'd0, 1'b0, 1'b0);
        chk("bad_err", 32'(err), 1);
        chk("bad_occ", 32'(occ), 0);

`ifdef STQ_DUAL_DRAIN_EN
        reset_dut();
        repeat (2) drive(2'b11, 2'd0, 1'b0, 1'b0);
        drive(2'b00, 2'd2, 1'b0, 1'b1, 1'b1);
        drive(2'b00, 2'd2, 1'b0, 1'b1, 1'b1);
        chk("dual_free0", free_en, 32'h3);
        drive(2'b00, 2'd0, 1'b0, 1'b1, 1'b1);
        chk("dual_free1", free_en, 32'hC);
`endif
        drive(2'b00, 2'd0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
